// File: rtl/modulo_demux1_4.sv
// Receive side of the 4:1 time-multiplexed link: steps the upstream mux select,
// collects one sample per slot and publishes the rebuilt 4-channel frame.
module modulo_demux1_4 #(
  parameter int unsigned DATA_W = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  input_valid,
  input  logic [DATA_W-1:0]     input_d,
  input  logic                  input_sync,
  output logic [1:0]            out_sel,
  output logic [4*DATA_W-1:0]   out_e,
  output logic                  out_frame_valid,
  output logic                  out_frame_err
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t                   state, state_nxt;
  logic [1:0]               sel_nxt;
  logic [3:1][DATA_W-1:0]   shadow, shadow_nxt;
  logic [4*DATA_W-1:0]      e_nxt;
  logic                     fv_nxt, fe_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      out_sel         <= '0;
      shadow          <= '0;
      out_e           <= '0;
      out_frame_valid <= 1'b0;
      out_frame_err   <= 1'b0;
    end else begin
      state           <= state_nxt;
      out_sel         <= sel_nxt;
      shadow          <= shadow_nxt;
      out_e           <= e_nxt;
      out_frame_valid <= fv_nxt;
      out_frame_err   <= fe_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sel_nxt    = out_sel;
    shadow_nxt = shadow;
    e_nxt      = out_e;
    fv_nxt     = 1'b0;
    fe_nxt     = 1'b0;
    if (input_valid) begin
      unique case (state)
        IDLE: begin
          if (input_sync) begin
            shadow_nxt[3] = input_d;
            sel_nxt       = 2'd1;
            state_nxt     = COLLECT;
          end
        end
        COLLECT: begin
          if (input_sync) begin
            // Re-sync: drop the partial frame and restart on this sample
            fe_nxt        = 1'b1;
            shadow_nxt[3] = input_d;
            sel_nxt       = 2'd1;
          end else if (out_sel == 2'd3) begin
            e_nxt     = {shadow, input_d};
            fv_nxt    = 1'b1;
            sel_nxt   = 2'd0;
            state_nxt = IDLE;
          end else begin
            unique case (out_sel)
              2'd1:    shadow_nxt[2] = input_d;
              2'd2:    shadow_nxt[1] = input_d;
              default: ;
            endcase
            sel_nxt = out_sel + 2'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modulo_demux1_4.sv
// Scoreboard bench for modulo_demux1_4: a sample-list reference model queues
// expected frame/error events; a negedge monitor pops and compares them.
module tb_modulo_demux1_4;

  localparam int unsigned DATA_W = 1;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                input_valid = 1'b0;
  logic [DATA_W-1:0]   input_d = '0;
  logic                input_sync = 1'b0;
  logic [1:0]          out_sel;
  logic [4*DATA_W-1:0] out_e;
  logic                out_frame_valid;
  logic                out_frame_err;

  modulo_demux1_4 #(.DATA_W(DATA_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .input_valid     (input_valid),
    .input_d         (input_d),
    .input_sync      (input_sync),
    .out_sel         (out_sel),
    .out_e           (out_e),
    .out_frame_valid (out_frame_valid),
    .out_frame_err   (out_frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    logic [3:0] frame;
  } ev_t;

  ev_t  exp_q[$];
  logic samples[$];
  logic [3:0] last_frame = '0;
  int   checks = 0;
  int   errors = 0;
  bit   lb_mode = 1'b0;
  logic [3:0] lb_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is the ordered list of samples since the last sync
  task automatic model_accept(input bit s, input logic d);
    ev_t ev;
    if (s) begin
      if (samples.size() != 0) begin
        ev.err = 1'b1;
        ev.frame = last_frame;
        exp_q.push_back(ev);
      end
      samples.delete();
      samples.push_back(d);
    end else if (samples.size() != 0) begin
      samples.push_back(d);
      if (samples.size() == 4) begin
        last_frame = lb_mode ? lb_word
                             : {samples[0], samples[1], samples[2], samples[3]};
        ev.err = 1'b0;
        ev.frame = last_frame;
        exp_q.push_back(ev);
        samples.delete();
      end
    end
  endtask

  task automatic drive(input bit v, input bit s, input logic d);
    logic [3:0] w;
    int idx;
    @(negedge clk);
    check("out_sel", 32'(out_sel), 32'(samples.size()));
    if (lb_mode) begin
      w = lb_word;
      idx = 3 - int'(out_sel);
      d = w[idx];
    end
    input_valid = v;
    input_sync  = s;
    input_d     = d;
    if (v) model_accept(s, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    ev_t ev;
    forever begin
      @(negedge clk);
      if (out_frame_valid && out_frame_err) check("pulse_exclusive", 32'd1, 32'd0);
      if (out_frame_valid || out_frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, out_frame_err, out_frame_valid}, 32'd0);
        end else begin
          ev = exp_q.pop_front();
          check("pulse_kind_err", 32'(out_frame_err), 32'(ev.err));
          check("out_e", 32'(out_e), 32'(ev.frame));
        end
      end
    end
  end

  initial begin : stim
    bit v, s;
    #12;
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_out_e", 32'(out_e), 32'd0);
    check("rst_fv", 32'(out_frame_valid), 32'd0);
    check("rst_fe", 32'(out_frame_err), 32'd0);
    reset_n = 1'b1;

    // Basic frame
    drive(1, 1, 1); drive(1, 0, 0); drive(1, 0, 1); drive(1, 0, 1);
    idle(2);
    check("basic_out_e", 32'(out_e), 32'hB);

    // Gap mid-frame, then back-to-back frame
    drive(1, 1, 1); drive(1, 0, 0); idle(3); drive(1, 0, 1); drive(1, 0, 1);
    drive(1, 1, 0); drive(1, 0, 1); drive(1, 0, 1); drive(1, 0, 0);
    idle(2);
    check("b2b_out_e", 32'(out_e), 32'h6);

    // Mid-frame re-sync
    drive(1, 1, 1); drive(1, 0, 1); drive(1, 1, 0); drive(1, 0, 0);
    idle(1);
    check("resync_hold_out_e", 32'(out_e), 32'h6);
    drive(1, 0, 0); drive(1, 0, 1);
    idle(2);
    check("resync_out_e", 32'(out_e), 32'h1);

    // Unsynced data in IDLE, and sync without valid
    for (int i = 0; i < 5; i++) drive(1, 0, 1'(i));
    drive(0, 1, 1);
    idle(2);

    // Async reset between edges after 2 samples
    drive(1, 1, 1); drive(1, 0, 1);
    @(negedge clk);
    input_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("arst_out_sel", 32'(out_sel), 32'd0);
    check("arst_out_e", 32'(out_e), 32'd0);
    check("arst_fv", 32'(out_frame_valid), 32'd0);
    check("arst_fe", 32'(out_frame_err), 32'd0);
    samples.delete();
    last_frame = '0;
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 0, 1);
    drive(1, 1, 1); drive(1, 0, 1); drive(1, 0, 1); drive(1, 0, 1);
    idle(2);
    check("arst_frame_out_e", 32'(out_e), 32'hF);

    // Loopback through a 4:1 mux model
    lb_mode = 1'b1;
    for (int f = 0; f < 100; f++) begin
      lb_word = 4'($urandom);
      drive(1, 1, 1'b0);
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        drive(1, 0, 1'b0);
      end
    end
    idle(2);
    lb_mode = 1'b0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 9) < 2);
      drive(v, s, 1'($urandom));
    end
    idle(3);
    check("pending_events", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/modulo_demux1_4.md
# modulo_demux1_4

Receive-side counterpart of the team's 4:1 mux: rebuilds a 4-channel frame from a time-multiplexed serial stream. The block drives the mux select through `out_sel` and takes the mux output as its data input. It captures one sample per slot and presents the complete frame on a parallel register. A new `out_e` is published only when all four slots of a synchronized frame have arrived.

## Interface
- `DATA_W`, default 1: width of each channel sample.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `input_valid`  in  1  `input_d` carries the sample for the current slot this cycle.
- `input_d`  in  DATA_W  serial sample, taken from the mux output.
- `input_sync`  in  1  qualified by `input_valid`; marks the sample as slot 0, the start of a frame.
- `out_sel`  out  2  current slot index; drives the upstream mux select.
- `out_e`  out  4*DATA_W  last complete frame; channel k is bits `[DATA_W*(k+1)-1 : DATA_W*k]`.
- `out_frame_valid`  out  1  one-cycle pulse; `out_e` updated on this edge.
- `out_frame_err`  out  1  one-cycle pulse; a partial frame was discarded.

## Operation
- **Slot-to-channel mapping** matches the mux: slot s (`out_sel`=s) carries channel 3-s. Slot 00 is channel 3, 01 is channel 2, 10 is channel 1, 11 is channel 0.
- **State:** 2-state FSM (IDLE, COLLECT), a 2-bit slot counter (`out_sel`), and a shadow register of 3 channels.
- **IDLE:**
  - `out_sel`=0.
  - `input_valid` & !`input_sync`: sample ignored, no state change.
  - `input_valid` & `input_sync`: sample stored to shadow channel 3; slot becomes 1; go to COLLECT.
- **COLLECT, slot 1..2:** `input_valid` & !`input_sync` stores the sample to shadow channel 3-slot; slot increments.
- **COLLECT, slot 3:** `input_valid` & !`input_sync` completes the frame:
  - `out_e` loads shadow channels 3..1 plus the current sample as channel 0;
  - `out_frame_valid` pulses;
  - slot returns to 0; go to IDLE.
- **Re-sync mid-frame** (COLLECT, `input_valid` & `input_sync`):
  - `out_frame_err` pulses;
  - the partial frame is discarded and `out_e` is unchanged;
  - the sample starts a new frame: stored to channel 3, slot becomes 1, stay in COLLECT.
- **Gaps:** `input_valid`=0 holds all state. `input_sync` without `input_valid` is ignored. Gaps of any length are allowed mid-frame.
- **Continuous streaming:** a sync sample can be accepted in IDLE on the cycle right after a frame completes. Back-to-back frames therefore need no idle cycle.
- **Output visibility:** `out_e` changes only on frame completion; shadow contents are never visible on outputs.

## Timing
- **Reset values** (async assert, any cycle):
  - `out_sel`=0, `out_e`=0, `out_frame_valid`=0, `out_frame_err`=0;
  - FSM=IDLE, shadow=0.
- **Reset mid-frame:** the partial frame is lost with no error pulse. After release, a sync sample is needed to start a frame.
- **Registered outputs:** all outputs come from flops; no combinational path from input to output.
- **`out_sel` update:** changes on the edge that accepts a sample. The upstream mux presents the next slot's data from the following cycle.
- **Frame latency:** `out_e` and `out_frame_valid` update on the edge sampling the 4th valid sample. With no gaps, a frame takes 4 cycles from sync to pulse.
- **Pulse exclusivity:** `out_frame_valid` and `out_frame_err` are never high in the same cycle, and each lasts exactly one cycle.
- **Counter wrap:** the slot counter never wraps on its own. The 3→0 transition happens only on frame completion.

## Test plan
- **Basic frame:** `DATA_W`=1; reset; then valid samples 1 (sync), 0, 1, 1 on consecutive cycles → `out_sel` steps 0,1,2,3,0; `out_e`=4'b1011 with one `out_frame_valid` pulse; `out_frame_err` stays 0.
- **Gaps and back-to-back:**
  - Same frame with `input_valid` low for 3 cycles between slots 1 and 2 → identical `out_e`; `out_sel` holds at 2 during the gap.
  - Then an immediate second frame 0 (sync), 1, 1, 0 → `out_e`=4'b0110.
- **Mid-frame re-sync:** sync samples 1, 1, then 0 with sync, then 0, 0, 1 → one `out_frame_err` pulse at the 3rd sample; `out_e`=4'b0001; the previous `out_e` is held until completion.
- **Unsynced data:** in IDLE, 5 valid samples with no sync → no state change; `out_sel`=0; no pulses.
- **Async reset mid-frame:** assert `reset_n`=0 after 2 samples, between edges → all outputs 0 immediately. Then a full frame 1, 1, 1, 1 → `out_e`=4'b1111.
- **Loopback:** `DATA_W`=1 with the team's 4:1 mux driven by `out_sel` and a random 4-bit word held on its inputs; 100 frames → `out_e` equals the word each frame.
